// File: rtl/fpga_link_pkg.sv
// Shared types and constants for the FPGA-to-FPGA serial link.
package fpga_link_pkg;

    localparam int   DATA_BITS = 8;
    localparam logic LINE_IDLE = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

endpackage

// File: rtl/fpga_serial_rx_if.sv
// Receive-side link bundle: raw serial line in, parallel byte and strobes out.
interface fpga_serial_rx_if;
    import fpga_link_pkg::*;

    logic                 data_in_s;
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 frame_error;
    logic                 shift;
    logic                 busy;

    modport master (
        input  data_in_s,
        output data_out,
        output data_valid,
        output frame_error,
        output shift,
        output busy
    );

    modport slave (
        output data_in_s,
        input  data_out,
        input  data_valid,
        input  frame_error,
        input  shift,
        input  busy
    );

endinterface

// File: rtl/fpga_bit_sync.sv
// Two-flop synchronizer with falling-edge detect; all flops reset to the idle line level.
module fpga_bit_sync
    import fpga_link_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic sync_out,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    // The third copy only feeds edge detection; it never drives the datapath.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta <= LINE_IDLE;
            sync <= LINE_IDLE;
            prev <= LINE_IDLE;
        end else begin
            meta <= async_in;
            sync <= meta;
            prev <= sync;
        end
    end

    assign sync_out = sync;
    assign fall     = prev & ~sync;

endmodule

// File: rtl/fpga_serial_rx.sv
// Asynchronous-frame receiver (start, 8 data LSB first, stop) with framing-error detection.
// Define FPGA_RX_PARITY_EN to add an even-parity bit between the data and stop bits.
module fpga_serial_rx
    import fpga_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic             clock,
    input  logic             reset,
    fpga_serial_rx_if.master rx
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    rx_state_t            state;
    rx_state_t            state_next;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 rx_s;
    logic                 rx_fall;
    logic                 cnt_clear;
    logic                 take_bit;
    logic                 load_out;
    logic                 flag_err;
    logic                 parity_good;

    fpga_bit_sync u_sync (
        .clock    (clock),
        .reset    (reset),
        .async_in (rx.data_in_s),
        .sync_out (rx_s),
        .fall     (rx_fall)
    );

`ifdef FPGA_RX_PARITY_EN
    logic take_par;
    logic par_ok;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            par_ok <= 1'b1;
        end else if (take_par) begin
            par_ok <= ~^{shreg, rx_s};
        end
    end

    assign parity_good = par_ok;
`else
    assign parity_good = 1'b1;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_clear  = 1'b0;
        take_bit   = 1'b0;
        load_out   = 1'b0;
        flag_err   = 1'b0;
`ifdef FPGA_RX_PARITY_EN
        take_par   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (rx_fall) begin
                    state_next = START;
                    cnt_clear  = 1'b1;
                end
            end
            // A start bit that is high again at mid-bit was only a glitch.
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_clear  = 1'b1;
                    state_next = (rx_s == LINE_IDLE) ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_clear = 1'b1;
                    take_bit  = 1'b1;
                    if (bit_idx == IDX_LAST) begin
`ifdef FPGA_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
            end
`ifdef FPGA_RX_PARITY_EN
            PARITY: begin
                if (cnt == BIT_LAST) begin
                    cnt_clear  = 1'b1;
                    take_par   = 1'b1;
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_clear = 1'b1;
                    if (rx_s == LINE_IDLE) begin
                        load_out   = parity_good;
                        flag_err   = ~parity_good;
                        state_next = IDLE;
                    end else begin
                        flag_err   = 1'b1;
                        state_next = BREAK;
                    end
                end
            end
            // Hold off until the line returns high so a stuck-low line cannot re-trigger.
            BREAK: begin
                if (rx_s == LINE_IDLE) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            if (cnt_clear || state == IDLE || state == BREAK) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            if (state == START) begin
                bit_idx <= '0;
            end else if (take_bit) begin
                bit_idx <= bit_idx + IDX_W'(1);
            end
            if (take_bit) begin
                shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            end
        end
    end

    // Strobes are registered, so each lands one clock after its sample point.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx.data_out    <= '0;
            rx.data_valid  <= 1'b0;
            rx.frame_error <= 1'b0;
            rx.shift       <= 1'b0;
        end else begin
            rx.data_valid  <= load_out;
            rx.frame_error <= flag_err;
            rx.shift       <= take_bit;
            if (load_out) begin
                rx.data_out <= shreg;
            end
        end
    end

    assign rx.busy = (state != IDLE);

endmodule
